mips_alu_md: RTL and testbench
==============================

MIPS_ALU_MD -- requirements
Module: mips_alu_md

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width (legal 8..64, even).
REQ-002 The block SHALL have these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept.
- ALUctrl  in  4  opcode.
- A, B  in  WIDTH  operands.
- out_valid  out  1  one-cycle result pulse.
- ALUOut  out  WIDTH  registered result.
- Zero  out  1  ALUOut==0.
- Overflow  out  1  signed overflow, ADD/SUB only.
- hi, lo  out  WIDTH  HI/LO register contents.

Function
REQ-003 The block SHALL accept an operation on a rising edge where in_valid && in_ready are both high; in_valid while in_ready is low SHALL be ignored, with no state change.
REQ-004 Opcodes SHALL be:
- Single-cycle: 0 AND, 1 OR, 2 ADD, 3 SLTU, 4 XOR, 6 SUB, 7 SLT (signed), 12 NOR, 13 MFHI, 14 MFLO.
- Multi-cycle: 8 MULT, 9 MULTU, 10 DIV, 11 DIVU.
- Opcodes 5 and 15: result 0.
REQ-005 Single-cycle ops: ALUOut, Zero, Overflow and out_valid SHALL update on the accepting edge, giving latency 1, and in_ready SHALL stay high, allowing back-to-back issue every cycle.
REQ-006 ADD/SUB SHALL wrap modulo 2^WIDTH. Overflow SHALL be 1 when the signed result overflows and 0 for every other opcode.
REQ-007 SLT/SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-008 The FSM SHALL have states IDLE, MUL, DIV and DONE:
- IDLE -> MUL on an accepted MULT/MULTU.
- IDLE -> DIV on an accepted DIV/DIVU.
- MUL or DIV -> DONE after exactly WIDTH iteration cycles.
- DONE -> IDLE on the next cycle.
REQ-009 in_ready SHALL be high only in IDLE.
REQ-010 Multiply SHALL use shift-add, one bit per cycle, and produce a 2*WIDTH product with HI = upper half and LO = lower half; signed variants SHALL operate on magnitudes and negate the result when the operand signs differ.
REQ-011 Divide SHALL use restoring division, one quotient bit per cycle, with LO = quotient and HI = remainder; signed quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-012 Divide by zero SHALL still take full latency, giving LO = all ones and HI = A.
REQ-013 Signed most-negative / -1 SHALL give LO = most-negative and HI = 0.
REQ-014 In DONE, the block SHALL write HI and LO, drive ALUOut = new LO with Zero computed from it, and pulse out_valid for one cycle; total latency from the accept edge to the out_valid edge SHALL be WIDTH+1 cycles.
REQ-015 MFHI/MFLO accepted in the cycle after DONE SHALL return the updated HI/LO.
REQ-016 Outputs other than out_valid SHALL hold their value between results.
REQ-017 Operand changes after acceptance SHALL NOT affect an in-flight multi-cycle operation, because operands are latched at acceptance.

Reset
REQ-018 Asserting reset SHALL asynchronously force:
- state = IDLE, in_ready = 1;
- out_valid = 0, ALUOut = 0, Zero = 1, Overflow = 0;
- hi = 0, lo = 0;
- iteration counter = 0.
REQ-019 Reset during MUL/DIV SHALL abort the operation with no out_valid and no HI/LO write.
REQ-020 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-021 Shared package mips_alu_pkg SHALL hold the opcode localparams, the state enum (IDLE, MUL, DIV, DONE) and the WIDTH default.
REQ-022 The iterative multiply/divide datapath (operand latches, accumulator, counter, sign fix-up) SHALL be one sub-module, mips_muldiv_core, controlled by the top-level FSM.
REQ-023 The single-cycle ALU function SHALL be combinational logic feeding the ALUOut register.

Verification
REQ-024 The bench, at WIDTH=32, SHALL cover these directed scenarios:
- ADD 0x7FFFFFFF+1 -> ALUOut=0x80000000, Overflow=1, out_valid 1 cycle later.
- SUB 5-5 -> ALUOut=0, Zero=1; SLT -1,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
- MULT -3 x 7 -> out_valid exactly 33 cycles after accept, HI=0xFFFFFFFF, LO=0xFFFFFFEB; in_ready low throughout; an in_valid ADD offered during busy is ignored.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF then MFHI next cycle -> 0xFFFFFFFE; MFLO -> 0x00000001.
- Reset asserted at cycle 10 of a DIV -> immediate in_ready=1, hi=lo=0, no out_valid; a new ADD accepted on the first edge after release.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS ALU with iterative multiply/divide:
// opcodes, controller states and the default datapath width.
package mips_alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLTU  = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_MFHI  = 4'd13;
  localparam logic [3:0] OP_MFLO  = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mips_muldiv_core.sv
// Iterative multiply/divide datapath: latches operand magnitudes on start,
// runs one shift-add or restoring-divide step per cycle, fixes signs on output.
module mips_muldiv_core
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, mb_reg, acc_reg, sh_reg;
  logic             div_reg, negq_reg, negr_reg, div0_reg;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg = op_signed & a[WIDTH-1];
  assign b_neg = op_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: acc:sh holds the running product, sh initially the multiplier.
  // Divide: sh shifts the dividend out while collecting quotient bits, acc is the remainder.
  assign mul_sum  = {1'b0, acc_reg} + (sh_reg[0] ? {1'b0, mb_reg} : {(WIDTH+1){1'b0}});
  assign div_sh   = {acc_reg, sh_reg[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mb_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      a_reg    <= '0;
      mb_reg   <= '0;
      acc_reg  <= '0;
      sh_reg   <= '0;
      div_reg  <= 1'b0;
      negq_reg <= 1'b0;
      negr_reg <= 1'b0;
      div0_reg <= 1'b0;
    end else if (start) begin
      cnt_reg  <= '0;
      a_reg    <= a;
      mb_reg   <= op_div ? b_mag : a_mag;
      sh_reg   <= op_div ? a_mag : b_mag;
      acc_reg  <= '0;
      div_reg  <= op_div;
      negq_reg <= a_neg ^ b_neg;
      negr_reg <= a_neg;
      div0_reg <= op_div && (b == '0);
    end else if (step) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (div_reg) begin
        if (!div_diff[WIDTH]) begin
          acc_reg <= div_diff[WIDTH-1:0];
          sh_reg  <= {sh_reg[WIDTH-2:0], 1'b1};
        end else begin
          acc_reg <= div_sh[WIDTH-1:0];
          sh_reg  <= {sh_reg[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc_reg, sh_reg} <= {mul_sum, sh_reg[WIDTH-1:1]};
      end
    end
  end

  assign last     = (cnt_reg == LAST_CNT);
  assign prod     = {acc_reg, sh_reg};
  assign prod_fix = negq_reg ? -prod : prod;

  // Divide by zero bypasses sign fix-up: quotient all ones, remainder the raw dividend.
  always_comb begin
    if (!div_reg) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (div0_reg) begin
      hi_res = a_reg;
      lo_res = '1;
    end else begin
      hi_res = negr_reg ? -acc_reg : acc_reg;
      lo_res = negq_reg ? -sh_reg : sh_reg;
    end
  end

endmodule

// File: rtl/mips_alu_md.sv
// MIPS ALU top: single-cycle ops register straight into ALUOut, MULT/DIV run
// through the iterative core under an IDLE/MUL/DIV/DONE controller.
module mips_alu_md
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t state_reg, state_next;

  logic             accept, is_mul, is_div, core_last;
  logic [WIDTH-1:0] core_hi, core_lo, add_res, sub_res, alu_res;
  logic             alu_ovf;

  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (ALUctrl == OP_MULT) || (ALUctrl == OP_MULTU);
  assign is_div   = (ALUctrl == OP_DIV)  || (ALUctrl == OP_DIVU);
  assign add_res  = A + B;
  assign sub_res  = A - B;

  mips_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clock),
    .rst       (reset),
    .start     (accept && (is_mul || is_div)),
    .op_div    (ALUctrl[1]),
    .op_signed (~ALUctrl[0]),
    .a         (A),
    .b         (B),
    .step      ((state_reg == MUL) || (state_reg == DIV)),
    .last      (core_last),
    .hi_res    (core_hi),
    .lo_res    (core_lo)
  );

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUctrl)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_mul)      state_next = MUL;
        else if (accept && is_div) state_next = DIV;
      end
      MUL, DIV: if (core_last) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Multi-cycle accepts leave the visible outputs untouched until DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ALUOut    <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state_reg == DONE) begin
        hi        <= core_hi;
        lo        <= core_lo;
        ALUOut    <= core_lo;
        Zero      <= (core_lo == '0);
        Overflow  <= 1'b0;
        out_valid <= 1'b1;
      end else if (accept && !(is_mul || is_div)) begin
        ALUOut    <= alu_res;
        Zero      <= (alu_res == '0);
        Overflow  <= alu_ovf;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_md.sv
// Directed bench for mips_alu_md at WIDTH=32: single-cycle ops, multiply/divide
// results and latency, busy back-pressure, HI/LO forwarding and mid-op reset.
module tb_mips_alu_md;

  logic        clock, reset, in_valid, in_ready, out_valid, Zero, Overflow;
  logic [3:0]  ALUctrl;
  logic [31:0] A, B, ALUOut, hi, lo;

  int checks = 0;
  int errors = 0;

  mips_alu_md #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUctrl   (ALUctrl),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .ALUOut    (ALUOut),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .hi        (hi),
    .lo        (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUctrl  = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("op=%0d A=%h B=%h -> out_valid=%b ALUOut=%h Zero=%b Ovf=%b", op, a, b,
             out_valid, ALUOut, Zero, Overflow);
  endtask

  // Issues a multi-cycle op, scrambles operands, offers an ADD while busy,
  // then checks latency, in_ready during busy and the HI/LO result.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(op, a, b);
    A = 32'h1234_5678;
    B = 32'h0000_0003;
    lat = 0;
    while (!out_valid && lat < 60) begin
      chk({tag, "_busy_ready"}, in_ready, 1'b0);
      if (lat == 5) begin
        ALUctrl  = 4'd2;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_aluout"}, ALUOut, exp_lo);
    chk({tag, "_zero"}, Zero, exp_lo == 32'h0);
    $display("%s: lat=%0d hi=%h lo=%h", tag, lat, hi, lo);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    ALUctrl  = 4'd0;
    A        = '0;
    B        = '0;
    tick();
    tick();
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_aluout", ALUOut, 32'h0);
    chk("rst_zero", Zero, 1'b1);
    chk("rst_ovf", Overflow, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 1'b0;

    issue(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_valid", out_valid, 1'b1);
    chk("add_res", ALUOut, 32'h8000_0000);
    chk("add_ovf", Overflow, 1'b1);
    chk("add_zero", Zero, 1'b0);
    chk("add_ready", in_ready, 1'b1);
    tick();
    chk("add_pulse", out_valid, 1'b0);
    chk("add_hold", ALUOut, 32'h8000_0000);

    issue(4'd6, 32'd5, 32'd5);
    chk("sub_res", ALUOut, 32'h0);
    chk("sub_zero", Zero, 1'b1);
    chk("sub_ovf", Overflow, 1'b0);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    chk("slt_res", ALUOut, 32'd1);
    chk("slt_valid", out_valid, 1'b1);
    issue(4'd3, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_res", ALUOut, 32'd0);
    chk("sltu_zero", Zero, 1'b1);
    issue(4'd6, 32'h8000_0000, 32'd1);
    chk("subovf_res", ALUOut, 32'h7FFF_FFFF);
    chk("subovf_ovf", Overflow, 1'b1);
    issue(4'd0, 32'h0000_F0F0, 32'h0000_FF00);
    chk("and_res", ALUOut, 32'h0000_F000);
    chk("and_ovf", Overflow, 1'b0);
    issue(4'd4, 32'h0000_F0F0, 32'h0000_FF00);
    chk("xor_res", ALUOut, 32'h0000_0FF0);
    issue(4'd12, 32'h0000_0000, 32'h0000_0001);
    chk("nor_res", ALUOut, 32'hFFFF_FFFE);
    issue(4'd5, 32'hFFFF_FFFF, 32'h1);
    chk("op5_res", ALUOut, 32'h0);

    run_md("mult", 4'd8, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    chk("mult_ovf", Overflow, 1'b0);
    tick();
    chk("mult_pulse", out_valid, 1'b0);
    chk("mult_ready", in_ready, 1'b1);
    chk("mult_hold", ALUOut, 32'hFFFF_FFEB);

    run_md("div", 4'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", 4'd11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_md("divmin", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_md("divu", 4'd11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("multu", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(4'd13, 32'h0, 32'h0);
    chk("mfhi_res", ALUOut, 32'hFFFF_FFFE);
    chk("mfhi_valid", out_valid, 1'b1);
    issue(4'd14, 32'h0, 32'h0);
    chk("mflo_res", ALUOut, 32'h0000_0001);

    issue(4'd10, 32'd100, 32'd3);
    for (int i = 1; i < 10; i++) tick();
    chk("pre_rst_busy", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_aluout", ALUOut, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    issue(4'd2, 32'd3, 32'd4);
    chk("postrst_valid", out_valid, 1'b1);
    chk("postrst_res", ALUOut, 32'd7);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("postrst_no_valid", out_valid, 1'b0);
    end
    chk("postrst_lo", lo, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
